// File: rtl/shared_delay_pkg.sv
// Shared types and default widths for the shared delay arbiter.
package shared_delay_pkg;

  localparam int unsigned SD_N    = 4;
  localparam int unsigned SD_NREQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, else lowest set bit.
module rr_pick
  import shared_delay_pkg::*;
#(
  parameter int unsigned NREQ = SD_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;
  logic          hi_any;

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = PW'(i);
        if (PW'(i) >= ptr) begin
          hi_idx = PW'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  // Requests at or above the pointer win; otherwise wrap to the lowest set bit.
  always_comb begin
    valid  = |req;
    winner = hi_any ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/shared_delay_arbiter.sv
// Round-robin shared down-counting delay engine for NREQ requesters.
// Optional SHARED_DELAY_ABORT_EN: owner dropping req during RUN aborts the run without done.
module shared_delay_arbiter
  import shared_delay_pkg::*;
#(
  parameter int unsigned N    = SD_N,
  parameter int unsigned NREQ = SD_NREQ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] delay,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [N-1:0]      count
);

  localparam int unsigned PW = $clog2(NREQ);

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic [N-1:0]  pick_delay;
  logic [NREQ-1:0] pick_onehot;
  logic [PW:0]   ptr_inc;
  logic [PW-1:0] ptr_next;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Winner's delay slice and one-hot grant vector.
  always_comb begin
    pick_delay  = '0;
    pick_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == PW'(i)) begin
        pick_delay     = delay[i*N +: N];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  // Pointer advances to the slot after the winner, wrapping at NREQ.
  always_comb begin
    ptr_inc  = {1'b0, pick_idx} + (PW+1)'(1);
    ptr_next = (ptr_inc >= (PW+1)'(NREQ)) ? '0 : ptr_inc[PW-1:0];
  end

  // Arbitration, counter load/decrement and done pulse generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt    <= pick_onehot;
            count  <= pick_delay;
            rr_ptr <= ptr_next;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
`ifdef SHARED_DELAY_ABORT_EN
          if ((req & gnt) == '0) begin
            gnt   <= '0;
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else
`endif
          if (count == '0) begin
            done  <= gnt;
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count - N'(1);
          end
        end
        default: begin
          gnt   <= '0;
          count <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shared_delay_arbiter.md
Name: shared_delay_arbiter

Overview:
- Shares one N-bit down-counting delay engine between NREQ requesters.
- Each requester asks for a delay of `delay` cycles. The block grants requesters round-robin, loads the counter, counts it down to zero, then pulses `done` to the granted requester.
- Sits between the counter datapath and client FSMs that need timed waits (debounce, settle, back-off).

Parameters:
- N, 4, counter width in bits; delay range is 0 to 2^N-1.
- NREQ, 4, number of requesters; must be at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  request per requester; level; held until done or abort.
- delay  input  NREQ*N  flattened delay values; slice i is bits [i*N +: N]; sampled only at grant.
- gnt  output  NREQ  one-hot owner of the counter; all zeros when idle.
- done  output  NREQ  one-cycle pulse to the owner when its delay expires.
- busy  output  1  high whenever gnt is non-zero.
- count  output  N  current counter value; 0 when idle.

Behaviour:
- Clock and reset: clk; reset is asynchronous, active-high.
- Reset values: state=IDLE, gnt=0, done=0, busy=0, count=0, rr_ptr=0.
- States: IDLE and RUN. All outputs are registered.
- IDLE:
  - If any req bit is high, pick the first set bit scanning from rr_ptr upward, wrapping modulo NREQ.
  - On that edge: gnt = one-hot(winner), count = delay slice of the winner, rr_ptr = (winner+1) mod NREQ, go to RUN.
  - done = 0 in IDLE, except for the pulse issued on the exit edge from RUN.
- RUN, count != 0: count decrements by 1 per edge. No wrap; the counter never goes below 0.
- RUN, count == 0:
  - On the next edge: done = gnt (one cycle), gnt = 0, count = 0, go to IDLE.
  - The done pulse is coincident with the first IDLE cycle.
- Latency: req seen at edge k → gnt at k. done is high during the cycle after edge k+delay+1.
  - delay=0 gives done one cycle after grant.
  - Total cycles from grant to done = delay+1.
- Re-request:
  - A requester still asserting req in the cycle done is high is treated as a new request.
  - It competes under the rr_ptr rules; earliest regrant is the edge that ends the done cycle.
- Arbitration is evaluated only in IDLE. Requests arriving during RUN wait; there is no preemption.
- delay is sampled only on the grant edge. Later changes to it are ignored.
- All-ones delay (2^N-1): counts fully to 0 with no overflow.
- reset mid-RUN: immediate return to reset values; no done is issued.

Optional Feature:
- Macro: SHARED_DELAY_ABORT_EN.
- Defined: in RUN, if req[owner] is low at an edge, go to IDLE on that edge. gnt=0, count=0, done stays 0, rr_ptr is unchanged from the grant. Abort takes priority over expiry on the same edge.
- Undefined: req is ignored after grant; the run always completes and done pulses even if req has dropped.

Decomposition:
- Package shared_delay_pkg contains:
  - state enum {IDLE, RUN};
  - default width constants SD_N=4, SD_NREQ=4.
- Sub-module rr_pick (parameter NREQ):
  - Combinational round-robin picker; inputs req and ptr; outputs valid and winner index.
  - Instantiated once.
- The counter is local to the top: load/decrement with a zero floor, not free-running wrap.

Test Plan:
- Reset: assert reset mid-RUN with count=5 → gnt=0, count=0, busy=0 immediately; no done pulse after release.
- Single request: req=0001, delay0=3 → gnt=0001 same edge; count 3,2,1,0; done=0001 for exactly one cycle; total 4 cycles from grant to done.
- Zero delay: req=0100, delay2=0 → gnt=0100, count=0; done=0100 on the next cycle.
- Round-robin: req=1111 held, all delays=1 → grant order 0,1,2,3,0; each done pulse one cycle long; never two gnt bits set.
- Max delay: delay=15 (N=4) → 16 cycles from grant to done; count never wraps to 15 after 0.
- Abort (SHARED_DELAY_ABORT_EN): grant req1 with delay=6, drop req1 when count=3 → next edge IDLE, done stays 0, pending req3 is granted on the following edge. Without the macro, done=0010 still pulses.
